// File: rtl/eem16_sweep_ctrl.sv
// eem16_sweep_ctrl
//   Hardware self-test sequencer for the 3-input minterm network z = m1+m2+m6.
//   A start request makes it drive x2:x1:x0 through rows 0..7. Each row is held
//   for SETTLE_CYCLES clocks and then z is sampled for one clock. The captured
//   8-bit truth table is compared against EXPECTED.
//
//   Optional feature (compile-time macro EEM16_SWEEP_ERRCNT_EN):
//     adds the err_cnt output, which counts rows where z != EXPECTED[row].
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous reset, active low
//   start     in   level, sampled only in IDLE; begins a sweep
//   abort     in   synchronous; cancels a sweep in DRIVE/SAMPLE
//   z         in   output of the network under test
//   x0/x1/x2  out  network inputs, row index LSB..MSB
//   busy      out  high during DRIVE/SAMPLE
//   done      out  one-cycle pulse when a sweep completes
//   truth     out  captured table, bit i = z at row i
//   pass      out  truth == EXPECTED, updated with done
//   err_cnt   out  [3:0] mismatching rows (only with EEM16_SWEEP_ERRCNT_EN)
module eem16_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  EXPECTED      = 8'h46
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       z,
  output logic       x0,
  output logic       x1,
  output logic       x2,
  output logic       busy,
  output logic       done,
  output logic [7:0] truth,
  output logic       pass
`ifdef EEM16_SWEEP_ERRCNT_EN
  ,
  output logic [3:0] err_cnt
`endif
);

  localparam int unsigned    CW          = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0]  SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } state_e;

  state_e        state_q;
  logic [2:0]    row_q;
  logic [2:0]    x_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    truth_q;
  logic [7:0]    truth_d;
  logic          busy_q;
  logic          done_q;
  logic          pass_q;
`ifdef EEM16_SWEEP_ERRCNT_EN
  logic [3:0]    err_q;
`endif

  // Table including the bit being sampled this cycle, so pass can be
  // registered on the same edge that captures row 7.
  always_comb begin
    truth_d        = truth_q;
    truth_d[row_q] = z;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      x_q     <= '0;
      cnt_q   <= '0;
      truth_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef EEM16_SWEEP_ERRCNT_EN
      err_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_DRIVE;
            row_q   <= '0;
            x_q     <= '0;
            cnt_q   <= '0;
            truth_q <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
`ifdef EEM16_SWEEP_ERRCNT_EN
            err_q   <= '0;
`endif
          end
        end

        S_DRIVE, S_SAMPLE: begin
          if (abort) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            x_q     <= '0;
            cnt_q   <= '0;
            truth_q <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef EEM16_SWEEP_ERRCNT_EN
            err_q   <= '0;
`endif
          end else if (state_q == S_DRIVE) begin
            if (cnt_q == SETTLE_LAST) begin
              state_q <= S_SAMPLE;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end else begin
            truth_q <= truth_d;
`ifdef EEM16_SWEEP_ERRCNT_EN
            if (z != EXPECTED[row_q]) begin
              err_q <= err_q + 4'd1;
            end
`endif
            if (row_q == 3'd7) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (truth_d == EXPECTED);
            end else begin
              state_q <= S_DRIVE;
              row_q   <= row_q + 3'd1;
              x_q     <= row_q + 3'd1;
              cnt_q   <= '0;
            end
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign x0    = x_q[0];
  assign x1    = x_q[1];
  assign x2    = x_q[2];
  assign busy  = busy_q;
  assign done  = done_q;
  assign truth = truth_q;
  assign pass  = pass_q;
`ifdef EEM16_SWEEP_ERRCNT_EN
  assign err_cnt = err_q;
`endif

endmodule

// File: tb/tb_eem16_sweep_ctrl.sv
// Directed testbench for eem16_sweep_ctrl (SETTLE_CYCLES=2, EXPECTED=8'h46).
// A behavioural minterm network (golden / stuck-at-0 / stuck-at-1) drives z.
module tb_eem16_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       z;
  logic       x0, x1, x2;
  logic       busy;
  logic       done;
  logic [7:0] truth;
  logic       pass;
`ifdef EEM16_SWEEP_ERRCNT_EN
  logic [3:0] err_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int mode     = 0;   // 0 golden, 1 stuck-at-0, 2 stuck-at-1

  eem16_sweep_ctrl #(
    .SETTLE_CYCLES(2),
    .EXPECTED     (8'h46)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .abort  (abort),
    .z      (z),
    .x0     (x0),
    .x1     (x1),
    .x2     (x2),
    .busy   (busy),
    .done   (done),
    .truth  (truth),
    .pass   (pass)
`ifdef EEM16_SWEEP_ERRCNT_EN
    ,
    .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Network under test: z = m1 + m2 + m6
  always_comb begin
    z = 1'b0;
    case (mode)
      1:       z = 1'b0;
      2:       z = 1'b1;
      default: z = ({x2, x1, x0} == 3'd1) || ({x2, x1, x0} == 3'd2) ||
                   ({x2, x1, x0} == 3'd6);
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full sweep from IDLE. Cycle c is the c-th cycle after the accept edge.
  task automatic sweep(input logic [7:0] exp_truth, input logic exp_pass,
                       input logic [3:0] exp_err, input bit noise, input bit abort_in_done);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      chk("sweep_x", {29'd0, x2, x1, x0}, 32'((c - 1) / 3));
      chk("sweep_busy", {31'd0, busy}, 32'd1);
      chk("sweep_done_low", {31'd0, done}, 32'd0);
      start = (noise && c < 20 && (c % 2 == 1)) ? 1'b1 : 1'b0;
      tick();
    end
    start = 1'b0;
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd0);
    chk("done_truth", {24'd0, truth}, {24'd0, exp_truth});
    chk("done_pass", {31'd0, pass}, {31'd0, exp_pass});
`ifdef EEM16_SWEEP_ERRCNT_EN
    chk("done_err_cnt", {28'd0, err_cnt}, {28'd0, exp_err});
`else
    if (exp_err > 4'd8) $display("note: err_cnt above range requested");
`endif
    abort = abort_in_done;
    tick();
    abort = 1'b0;
    chk("after_done_low", {31'd0, done}, 32'd0);
    chk("hold_truth", {24'd0, truth}, {24'd0, exp_truth});
    chk("hold_pass", {31'd0, pass}, {31'd0, exp_pass});
  endtask

  initial begin
    int ndone;
    int d1;
    int d2;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    mode  = 0;
    #2;
    chk("rst_x", {29'd0, x2, x1, x0}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_truth", {24'd0, truth}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
`ifdef EEM16_SWEEP_ERRCNT_EN
    chk("rst_err_cnt", {28'd0, err_cnt}, 32'd0);
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Golden sweep with start toggling while busy
    sweep(8'h46, 1'b1, 4'd0, 1'b1, 1'b0);

    // Stuck-at faults; abort during DONE must not disturb the result
    mode = 1;
    sweep(8'h00, 1'b0, 4'd3, 1'b0, 1'b0);
    mode = 2;
    sweep(8'hFF, 1'b0, 4'd5, 1'b0, 1'b1);
    mode = 0;

    // Abort while x=100
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("abort_pre_x", {29'd0, x2, x1, x0}, 32'd4);
    tick();
    chk("abort_pre_truth", {24'd0, truth}, 32'h06);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_x", {29'd0, x2, x1, x0}, 32'd0);
    chk("abort_truth", {24'd0, truth}, 32'd0);
    chk("abort_pass", {31'd0, pass}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      tick();
    end
    chk("abort_no_done", 32'(ndone), 32'd0);

    // start held high: back-to-back sweeps
    ndone = 0;
    d1 = 0;
    d2 = 0;
    start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (done) begin
        ndone++;
        if (ndone == 1) d1 = c;
        if (ndone == 2) d2 = c;
      end
      if (c >= 1 && c <= 24)
        chk("b2b_x1", {29'd0, x2, x1, x0}, 32'((c - 1) / 3));
      if (c >= 27 && c <= 50)
        chk("b2b_x2", {29'd0, x2, x1, x0}, 32'((c - 27) / 3));
    end
    start = 1'b0;
    chk("b2b_ndone", 32'(ndone), 32'd2);
    chk("b2b_done1", 32'(d1), 32'd25);
    chk("b2b_done2", 32'(d2), 32'd51);
    chk("b2b_busy3", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("b2b_abort_busy", {31'd0, busy}, 32'd0);
    tick();

    // Asynchronous reset mid-sweep at row 5, then a clean sweep
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("mid_x", {29'd0, x2, x1, x0}, 32'd5);
    rst_n = 1'b0;
    #1;
    chk("midrst_x", {29'd0, x2, x1, x0}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_truth", {24'd0, truth}, 32'd0);
    chk("midrst_pass", {31'd0, pass}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("postrst_idle", {31'd0, busy}, 32'd0);
    sweep(8'h46, 1'b1, 4'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
